// File: rtl/pt_sweep_if.sv
// pt_sweep_if
// Groups the sweep engine's control, stimulus and result signals.
//   start      : request a sweep (engine samples it only while idle)
//   mode       : pattern select, latched together with start
//   dut_q      : response of the logic under test
//   stim       : stimulus vector driven into the logic under test
//   busy       : sweep in progress
//   done       : one-cycle pulse when a sweep finishes
//   err_cnt    : saturating mismatch count of the last sweep
//   fail       : at least one mismatch in the last sweep
//   first_fail : step number of the first mismatch (all ones if none)
// The master side drives start/mode/dut_q; the slave (engine) drives the rest.
interface pt_sweep_if #(
  parameter int WIDTH = 96,
  parameter int ERRW  = 8,
  parameter int IDXW  = $clog2(WIDTH + 1)
);
  logic             start;
  logic [1:0]       mode;
  logic             dut_q;
  logic [WIDTH-1:0] stim;
  logic             busy;
  logic             done;
  logic [ERRW-1:0]  err_cnt;
  logic             fail;
  logic [IDXW-1:0]  first_fail;

  modport master (
    output start, mode, dut_q,
    input  stim, busy, done, err_cnt, fail, first_fail
  );

  modport slave (
    input  start, mode, dut_q,
    output stim, busy, done, err_cnt, fail, first_fail
  );
endinterface

// File: rtl/pt_sweep_engine.sv
// pt_sweep_engine
// Stimulus-and-check engine for wide AND (product-term) logic. A sweep drives
// an all-ones baseline (step 0), then one vector per input bit (steps
// 1..WIDTH), each held DWELL clocks. The response is sampled on the last
// clock of each hold and compared with the expected AND result.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pt_sweep_if slave modport (start/mode/dut_q in, stim/busy/done/
//          err_cnt/fail/first_fail out), all outputs registered
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stim all ones, waiting for start; results of last sweep held
// BASE  | step 0, baseline all-ones vector, expected response 1
// SWEEP | steps 1..WIDTH, pattern vector for bit index bit_q
// DONE  | single cycle, done pulse, stim back to all ones
module pt_sweep_engine #(
  parameter int WIDTH = 96,
  parameter int DWELL = 4,
  parameter int ERRW  = 8,
  parameter int IDXW  = $clog2(WIDTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  pt_sweep_if.slave   bus
);

  localparam int DWW = $clog2(DWELL);
  localparam int BW  = $clog2(WIDTH);
  localparam logic [DWW-1:0] LAST_DW  = DWW'(DWELL - 1);
  localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BASE  = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  logic [DWW-1:0]   dwell_q,      dwell_d;
  logic [BW-1:0]    bit_q,        bit_d;
  logic [1:0]       mode_q,       mode_d;
  logic [WIDTH-1:0] stim_q,       stim_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [ERRW-1:0]  err_cnt_q,    err_cnt_d;
  logic             fail_q,       fail_d;
  logic [IDXW-1:0]  first_fail_q, first_fail_d;

  logic             sample;
  logic             exp_bit;
  logic             mismatch;
  logic [IDXW-1:0]  step_num;

  // Pattern for bit index idx. Mode 3 is reserved and falls into the
  // walking-zero default.
  function automatic logic [WIDTH-1:0] make_stim(input logic [1:0] m,
                                                 input logic [BW-1:0] idx);
    logic [WIDTH-1:0] one_hot;
    logic [WIDTH-1:0] vec;
    one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    case (m)
      2'd1:    vec = one_hot;
      2'd2:    vec = idx[0] ? '0 : '1;
      default: vec = ~one_hot;
    endcase
    return vec;
  endfunction

  // Expected response and step number for the vector currently on stim.
  always_comb begin
    exp_bit  = 1'b1;
    step_num = '0;
    if (state_q == SWEEP) begin
      step_num = IDXW'(bit_q) + IDXW'(1);
      exp_bit  = (mode_q == 2'd2) ? ~bit_q[0] : 1'b0;
    end
  end

  assign sample   = (dwell_q == LAST_DW);
  assign mismatch = (bus.dut_q != exp_bit);

  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    bit_d        = bit_q;
    mode_d       = mode_q;
    stim_d       = stim_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_cnt_d    = err_cnt_q;
    fail_d       = fail_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE: begin
        stim_d = '1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d      = BASE;
          mode_d       = bus.mode;
          err_cnt_d    = '0;
          fail_d       = 1'b0;
          first_fail_d = '1;
          dwell_d      = '0;
          bit_d        = '0;
          busy_d       = 1'b1;
        end
      end

      BASE, SWEEP: begin
        dwell_d = sample ? '0 : dwell_q + DWW'(1);
        if (sample) begin
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRW'(1);
            fail_d = 1'b1;
            if (!fail_q) first_fail_d = step_num;
          end
          // The next vector goes out on the same edge that samples this one.
          if (state_q == BASE) begin
            state_d = SWEEP;
            bit_d   = '0;
            stim_d  = make_stim(mode_q, '0);
          end else if (bit_q == LAST_BIT) begin
            state_d = DONE;
            stim_d  = '1;
            done_d  = 1'b1;
          end else begin
            bit_d  = bit_q + BW'(1);
            stim_d = make_stim(mode_q, bit_q + BW'(1));
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        stim_d  = '1;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        stim_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dwell_q      <= '0;
      bit_q        <= '0;
      mode_q       <= 2'd0;
      stim_q       <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_q       <= 1'b0;
      first_fail_q <= '1;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      bit_q        <= bit_d;
      mode_q       <= mode_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_cnt_q    <= err_cnt_d;
      fail_q       <= fail_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.fail       = fail_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_pt_sweep_engine.sv
module tb_pt_sweep_engine;
  localparam int W = 8;
  localparam int D = 4;
  localparam int E = 8;
  localparam int STEPS = W + 1;

  typedef struct {
    logic [E-1:0] err;
    logic         fail;
    logic [3:0]   ff;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   dut_kind = 0;

  logic [W-1:0] vec_q[$];
  res_t         res_q[$];
  res_t         sat_q[$];

  always #5 clk = ~clk;

  pt_sweep_if #(.WIDTH(W), .ERRW(E)) bus ();
  pt_sweep_if #(.WIDTH(W), .ERRW(2)) sbus ();

  pt_sweep_engine #(.WIDTH(W), .DWELL(D), .ERRW(E)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  pt_sweep_engine #(.WIDTH(W), .DWELL(D), .ERRW(2)) u_sat (
    .clk(clk), .rst(rst), .bus(sbus.slave)
  );

  // Behavioural stand-ins for the logic under test.
  function automatic logic model_dut(input int kind, input logic [W-1:0] v);
    case (kind)
      1:       return &(v | 8'h08);   // bit 3 stuck: ignored by the AND
      2:       return ~&v;
      default: return &v;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_vec(input logic [1:0] m, input int k);
    logic [W-1:0] one;
    int i;
    if (k == 0) return 8'hFF;
    i = k - 1;
    one = 8'h01 << i;
    case (m)
      2'd1:    return one;
      2'd2:    return (i % 2 == 0) ? 8'hFF : 8'h00;
      default: return ~one;
    endcase
  endfunction

  function automatic logic exp_resp(input logic [1:0] m, input int k);
    if (k == 0) return 1'b1;
    if (m == 2'd2) return ((k - 1) % 2 == 0);
    return 1'b0;
  endfunction

  function automatic res_t model_sweep(input logic [1:0] m, input int kind,
                                       input int errw);
    res_t r;
    int   maxe;
    maxe = (1 << errw) - 1;
    r.err = '0; r.fail = 1'b0; r.ff = 4'hF;
    for (int k = 0; k < STEPS; k++) begin
      if (model_dut(kind, exp_vec(m, k)) !== exp_resp(m, k)) begin
        if (!r.fail) r.ff = 4'(k);
        r.fail = 1'b1;
        if (int'(r.err) < maxe) r.err = r.err + 1'b1;
      end
    end
    return r;
  endfunction

  assign bus.dut_q  = model_dut(dut_kind, bus.stim);
  assign sbus.dut_q = ~&sbus.stim;

  task automatic run_sweep(input logic [1:0] m, input int kind, input int poke);
    logic [W-1:0] cur;
    res_t         r;
    dut_kind = kind;
    for (int k = 0; k < STEPS; k++) vec_q.push_back(exp_vec(m, k));
    res_q.push_back(model_sweep(m, kind, E));
    @(negedge clk);
    bus.mode  = m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cur = '0;
    for (int c = 0; c < STEPS * D; c++) begin
      if (c % D == 0) cur = vec_q.pop_front();
      total++;
      if (bus.stim !== cur) begin
        bad++; $display("FAIL stim m%0d c%0d got=%h exp=%h", m, c, bus.stim, cur);
      end
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++; $display("FAIL busy_done c%0d got=%b%b exp=10", c, bus.busy, bus.done);
      end
      if (c == poke) begin
        bus.start = 1'b1;
        bus.mode  = ~m;
      end else begin
        bus.start = 1'b0;
        bus.mode  = m;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.stim !== 8'hFF) begin
      bad++; $display("FAIL done_cycle got=%b%b/%h exp=11/ff", bus.done, bus.busy, bus.stim);
    end
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL after_done got=%b%b exp=00", bus.done, bus.busy);
    end
    r = res_q.pop_front();
    total++;
    if (bus.err_cnt !== r.err || bus.fail !== r.fail || bus.first_fail !== r.ff) begin
      bad++; $display("FAIL result m%0d kind%0d got=%0d/%b/%0d exp=%0d/%b/%0d", m, kind,
                      bus.err_cnt, bus.fail, bus.first_fail, r.err, r.fail, r.ff);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (bus.stim !== 8'hFF || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.err_cnt !== 8'd0 || bus.fail !== 1'b0 || bus.first_fail !== 4'hF) begin
      bad++; $display("FAIL %s got=%h/%b/%b/%0d/%b/%h exp=ff/0/0/0/0/f", tag, bus.stim,
                      bus.busy, bus.done, bus.err_cnt, bus.fail, bus.first_fail);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0;
    sbus.start = 1'b0; sbus.mode = 2'd0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("reset_release");
  endtask

  task automatic test_clean_mode0();     run_sweep(2'd0, 0, -1); endtask
  task automatic test_walking_one();     run_sweep(2'd1, 0, -1); endtask
  task automatic test_toggle();          run_sweep(2'd2, 0, -1); endtask
  task automatic test_mode3();           run_sweep(2'd3, 0, -1); endtask
  task automatic test_stuck_input();     run_sweep(2'd0, 1, -1); endtask
  task automatic test_inverted_toggle(); run_sweep(2'd2, 2, -1); endtask
  task automatic test_restart_ignored(); run_sweep(2'd0, 1, 10); endtask

  task automatic test_abort();
    dut_kind = 1;
    @(negedge clk);
    bus.mode = 2'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5 * D + 1) @(posedge clk);
    #3;
    total++;
    if (bus.fail !== 1'b1 || bus.first_fail !== 4'd4 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL pre_abort got=%b/%0d/%b exp=1/4/1", bus.fail, bus.first_fail, bus.busy);
    end
    rst = 1'b1;
    #1;
    check_reset_vals("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    run_sweep(2'd0, 0, -1);
  endtask

  task automatic test_back_to_back();
    int   n;
    res_t r;
    dut_kind = 0;
    res_q.push_back(model_sweep(2'd0, 0, E));
    res_q.push_back(model_sweep(2'd0, 0, E));
    @(negedge clk);
    bus.mode = 2'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    repeat (STEPS * D + 1) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b exp=0", bus.busy);
    end
    r = res_q.pop_front();
    total++;
    if (bus.err_cnt !== r.err || bus.fail !== r.fail || bus.first_fail !== r.ff) begin
      bad++; $display("FAIL b2b_result1 got=%0d/%b/%0d exp=%0d/%b/%0d",
                      bus.err_cnt, bus.fail, bus.first_fail, r.err, r.fail, r.ff);
    end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1 || bus.stim !== 8'hFF) begin
      bad++; $display("FAIL b2b_restart got=%b/%h exp=1/ff", bus.busy, bus.stim);
    end
    bus.start = 1'b0;
    repeat (D) @(posedge clk);
    #1;
    total++;
    if (bus.stim !== exp_vec(2'd0, 1)) begin
      bad++; $display("FAIL b2b_step1 got=%h exp=%h", bus.stim, exp_vec(2'd0, 1));
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n >= 100) begin
      bad++; $display("FAIL b2b_timeout got=%0d exp<100", n);
    end
    r = res_q.pop_front();
    total++;
    if (bus.err_cnt !== r.err || bus.fail !== r.fail || bus.first_fail !== r.ff) begin
      bad++; $display("FAIL b2b_result2 got=%0d/%b/%0d exp=%0d/%b/%0d",
                      bus.err_cnt, bus.fail, bus.first_fail, r.err, r.fail, r.ff);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int   n;
    res_t r;
    sat_q.push_back(model_sweep(2'd0, 2, 2));
    @(negedge clk);
    sbus.mode = 2'd0; sbus.start = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    n = 0;
    while (sbus.done !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n !== STEPS * D) begin
      bad++; $display("FAIL sat_len got=%0d exp=%0d", n, STEPS * D);
    end
    r = sat_q.pop_front();
    total++;
    if (sbus.err_cnt !== r.err[1:0] || sbus.fail !== r.fail || sbus.first_fail !== r.ff) begin
      bad++; $display("FAIL sat_result got=%0d/%b/%0d exp=%0d/%b/%0d",
                      sbus.err_cnt, sbus.fail, sbus.first_fail, r.err[1:0], r.fail, r.ff);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_clean_mode0();
    test_walking_one();
    test_toggle();
    test_mode3();
    test_stuck_input();
    test_inverted_toggle();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
